// File: rtl/smachine_data_memory.sv
`timescale 1ns/1ps
// S-Machine data-memory responder: 256x16 word store behind a req/ack handshake
// with a fixed number of wait states between request capture and commit.
module smachine_data_memory #(
  parameter int DATA_W      = 16,
  parameter int ADDR_W      = 8,
  parameter int WAIT_STATES = 1
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              req,
  input  logic              read_write_memory,
  input  logic [ADDR_W-1:0] addr,
  input  logic [DATA_W-1:0] data_out_memory,
  output logic [DATA_W-1:0] data_in_memory,
  output logic              ack,
  output logic              busy
);

  localparam int         DEPTH     = 2 ** ADDR_W;
  localparam logic [3:0] WAIT_INIT = 4'(WAIT_STATES);

  typedef enum logic [1:0] {IDLE, WAIT, RESP} state_t;

  state_t              state_reg;
  logic [3:0]          cnt_reg;
  logic                rw_reg;
  logic [ADDR_W-1:0]   addr_reg;
  logic [DATA_W-1:0]   wdata_reg;
  logic [DATA_W-1:0]   mem [DEPTH];
  logic                commit;

  // The WAIT->RESP edge is the only point where the store or read data changes.
  assign commit = (state_reg == WAIT) && (cnt_reg == 4'd0);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_reg      <= IDLE;
      cnt_reg        <= 4'd0;
      rw_reg         <= 1'b0;
      addr_reg       <= '0;
      wdata_reg      <= '0;
      data_in_memory <= '0;
      ack            <= 1'b0;
      busy           <= 1'b0;
    end else begin
      case (state_reg)
        IDLE: begin
          if (req) begin
            rw_reg    <= read_write_memory;
            addr_reg  <= addr;
            wdata_reg <= data_out_memory;
            cnt_reg   <= WAIT_INIT;
            busy      <= 1'b1;
            state_reg <= WAIT;
          end
        end
        WAIT: begin
          if (cnt_reg == 4'd0) begin
            ack       <= 1'b1;
            state_reg <= RESP;
            if (!rw_reg) begin
              data_in_memory <= mem[addr_reg];
            end
          end else begin
            cnt_reg <= cnt_reg - 4'd1;
          end
        end
        RESP: begin
          ack       <= 1'b0;
          busy      <= 1'b0;
          state_reg <= IDLE;
        end
        default: begin
          ack       <= 1'b0;
          busy      <= 1'b0;
          state_reg <= IDLE;
        end
      endcase
    end
  end

  // Reset clears every word, so the store is a register array rather than block RAM.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem[i] <= '0;
      end
    end else if (commit && rw_reg) begin
      mem[addr_reg] <= wdata_reg;
    end
  end

  a_req_known: assert property (@(posedge clk) disable iff (!reset_n)
                                (state_reg == IDLE) |-> !$isunknown(req));

endmodule
